// File: rtl/seq_logic_unit.sv
// Multi-cycle AND/OR/XOR/NOR unit: SLICE bits per cycle, LSB slice first; optional SEQ_LOGIC_UNIT_POPCOUNT_EN.
// Latency K=WIDTH/SLICE cycles accept-to-out_valid; result held in DONE until out_ready.
// Backpressure: in_ready only in IDLE, out_valid only in DONE, both decoded from state.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcount
`endif
);

  localparam int K    = WIDTH / SLICE;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(K - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [SLICE-1:0] a_sl, b_sl, slice_res;
  logic [WIDTH-1:0] result_nxt;
  logic             last, accept;

  assign last   = (idx == LAST);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_sl = a_q[int'(idx)*SLICE +: SLICE];
    b_sl = b_q[int'(idx)*SLICE +: SLICE];
    case (op_q)
      2'b00:   slice_res = a_sl & b_sl;
      2'b01:   slice_res = a_sl | b_sl;
      2'b10:   slice_res = a_sl ^ b_sl;
      default: slice_res = ~(a_sl | b_sl);
    endcase
    result_nxt = result;
    result_nxt[int'(idx)*SLICE +: SLICE] = slice_res;
  end

`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
  localparam int PCW = $clog2(WIDTH + 1);

  function automatic logic [PCW-1:0] count_ones(input logic [SLICE-1:0] v);
    logic [PCW-1:0] sum;
    sum = '0;
    for (int i = 0; i < SLICE; i++) sum = sum + PCW'(v[i]);
    return sum;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || accept)       popcount <= '0;
    else if (state == BUSY)  popcount <= popcount + count_ones(slice_res);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      result <= '0;
      zero   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 2'b00;
    end else if (accept) begin
      idx    <= '0;
      result <= '0;
      zero   <= 1'b0;
      a_q    <= a;
      b_q    <= b;
      op_q   <= op;
    end else if (state == BUSY) begin
      result <= result_nxt;
      idx    <= last ? '0 : idx + 1'b1;
      // zero must reflect the slice being written this cycle, hence result_nxt
      if (last) zero <= (result_nxt == '0);
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed/random bench for seq_logic_unit at 32/8, 16/16 and 64/4.
module tb_seq_logic_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_zero;
  logic [1:0]  d_op;
  logic [31:0] d_a, d_b, d_result;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
  logic [1:0]  s_op;
  logic [15:0] s_a, s_b, s_result;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_zero;
  logic [1:0]  w_op;
  logic [63:0] w_a, w_b, w_result;
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
  logic [5:0]  d_popcount;
  logic [4:0]  s_popcount;
  logic [6:0]  w_popcount;
`endif

  int tests = 0;
  int fails = 0;

  seq_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .op(d_op),
    .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .result(d_result), .zero(d_zero)
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
    , .popcount(d_popcount)
`endif
  );

  seq_logic_unit #(.WIDTH(16), .SLICE(16)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .zero(s_zero)
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
    , .popcount(s_popcount)
`endif
  );

  seq_logic_unit #(.WIDTH(64), .SLICE(4)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .zero(w_zero)
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
    , .popcount(w_popcount)
`endif
  );

  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one op on the 32-bit unit, scramble inputs, return cycles to out_valid (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    d_op = op; d_a = a; d_b = b; d_in_valid = 1'b1;
    tick;
    d_in_valid = 1'b0; d_op = ~op; d_a = ~a; d_b = ~b;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      tick;
      if (d_out_valid) begin lat = c; break; end
    end
  endtask

  task automatic release_d;
    d_out_ready = 1'b1;
    tick;
    d_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    tests++; if (d_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", d_in_ready); end
    tests++; if (d_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", d_out_valid); end
    tests++; if (d_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", d_result); end
    tests++; if (d_zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b expected 0", d_zero); end
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
    tests++; if (d_popcount !== 6'd0) begin fails++; $display("FAIL reset_popcount: got %0d expected 0", d_popcount); end
`endif
    tests++; if (s_in_ready !== 1'b1 || w_in_ready !== 1'b1) begin fails++; $display("FAIL reset_other_in_ready: got %b%b expected 11", s_in_ready, w_in_ready); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_ops;
    logic [1:0]  t_op [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11};
    logic [31:0] t_a  [6] = '{32'h54524000, 32'h54524000, 32'h54524000, 32'h0, 32'h54524000, 32'h54524000};
    logic [31:0] t_b  [6] = '{32'h45920000, 32'h45920000, 32'h45920000, 32'h0, 32'h0, 32'h45920000};
    logic [31:0] t_r  [6] = '{32'h55D24000, 32'h44120000, 32'h11C04000, 32'hFFFFFFFF, 32'h0, 32'hAA2DBFFF};
    logic        t_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          t_p  [6] = '{9, 4, 5, 32, 0, 23};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat);
      tests++; if (lat != 4) begin fails++; $display("FAIL ops_latency[%0d]: got %0d expected 4", i, lat); end
      tests++; if (d_result !== t_r[i]) begin fails++; $display("FAIL ops_result[%0d]: got %h expected %h", i, d_result, t_r[i]); end
      tests++; if (d_zero !== t_z[i]) begin fails++; $display("FAIL ops_zero[%0d]: got %b expected %b", i, d_zero, t_z[i]); end
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
      tests++; if (int'(d_popcount) != t_p[i]) begin fails++; $display("FAIL ops_popcount[%0d]: got %0d expected %0d", i, d_popcount, t_p[i]); end
`else
      if (t_p[i] < 0) $display("bad table entry %0d", i);
`endif
      release_d;
      tests++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin fails++; $display("FAIL ops_release[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, d_out_valid, d_in_ready); end
    end
  endtask

  task automatic test_back_to_back;
    int held_bad = 0;
    int lat = -1;
    d_op = 2'b00; d_a = 32'h54524000; d_b = 32'h45920000; d_in_valid = 1'b1;
    tick;
    d_op = 2'b11; d_a = 32'hFFFFFFFF; d_b = 32'hFFFFFFFF;
    tests++; if (d_in_ready !== 1'b0) begin fails++; $display("FAIL bp_busy_in_ready: got %b expected 0", d_in_ready); end
    for (int c = 0; c < 4; c++) tick;
    tests++; if (d_out_valid !== 1'b1) begin fails++; $display("FAIL bp_done_valid: got %b expected 1", d_out_valid); end
    for (int c = 0; c < 10; c++) begin
      tick;
      if (d_out_valid !== 1'b1 || d_result !== 32'h44120000 || d_in_ready !== 1'b0) held_bad++;
    end
    tests++; if (held_bad != 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles expected 0", held_bad); end
    tests++; if (d_result !== 32'h44120000) begin fails++; $display("FAIL bp_result: got %h expected 44120000", d_result); end
    d_op = 2'b10; d_a = 32'hF0F0F0F0; d_b = 32'h0F0F0F0F; d_out_ready = 1'b1;
    tick;
    d_out_ready = 1'b0;
    tests++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_same_cycle_accept: got out_valid=%b in_ready=%b expected 0/1", d_out_valid, d_in_ready); end
    tick;
    d_in_valid = 1'b0; d_a = 32'h0; d_b = 32'h0;
    tests++; if (d_in_ready !== 1'b0) begin fails++; $display("FAIL bp_next_cycle_accept: got in_ready=%b expected 0", d_in_ready); end
    for (int c = 1; c <= 50; c++) begin
      tick;
      if (d_out_valid) begin lat = c; break; end
    end
    tests++; if (lat != 4) begin fails++; $display("FAIL bp2_latency: got %0d expected 4", lat); end
    tests++; if (d_result !== 32'hFFFFFFFF) begin fails++; $display("FAIL bp2_result: got %h expected ffffffff", d_result); end
    release_d;
  endtask

  task automatic test_mid_reset;
    int rose = 0;
    int lat;
    d_op = 2'b01; d_a = 32'h000000A5; d_b = 32'h0000005A; d_in_valid = 1'b1;
    tick;
    d_in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (d_in_ready !== 1'b1) begin fails++; $display("FAIL mrst_in_ready: got %b expected 1", d_in_ready); end
    tests++; if (d_result !== 32'h0) begin fails++; $display("FAIL mrst_result: got %h expected 0", d_result); end
    tests++; if (d_out_valid !== 1'b0 || d_zero !== 1'b0) begin fails++; $display("FAIL mrst_flags: got out_valid=%b zero=%b expected 0/0", d_out_valid, d_zero); end
    for (int c = 0; c < 8; c++) begin
      tick;
      if (d_out_valid) rose++;
    end
    tests++; if (rose != 0) begin fails++; $display("FAIL mrst_no_valid: got %0d valid cycles expected 0", rose); end
    run_op(2'b10, 32'h54524000, 32'h45920000, lat);
    tests++; if (lat != 4 || d_result !== 32'h11C04000) begin fails++; $display("FAIL mrst_after: got lat=%0d result=%h expected 4/11c04000", lat, d_result); end
    release_d;
  endtask

  task automatic test_k1;
    logic [15:0] exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      s_op = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      s_a = 16'($urandom);
      s_b = (i == 0) ? 16'h0 : 16'($urandom);
      exp = 16'(ref_op(s_op, 64'(s_a), 64'(s_b)));
      s_in_valid = 1'b1;
      tick;
      s_in_valid = 1'b0; s_a = ~s_a; s_b = ~s_b;
      lat = -1;
      for (int c = 1; c <= 50; c++) begin
        tick;
        if (s_out_valid) begin lat = c; break; end
      end
      tests++; if (lat != 1) begin fails++; $display("FAIL k1_latency[%0d]: got %0d expected 1", i, lat); end
      tests++; if (s_result !== exp || s_zero !== (exp == 16'h0)) begin fails++; $display("FAIL k1_result[%0d]: got %h/%b expected %h/%b", i, s_result, s_zero, exp, exp == 16'h0); end
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
      tests++; if (int'(s_popcount) != $countones(exp)) begin fails++; $display("FAIL k1_popcount[%0d]: got %0d expected %0d", i, s_popcount, $countones(exp)); end
`endif
      s_out_ready = 1'b1;
      tick;
      s_out_ready = 1'b0;
    end
  endtask

  task automatic test_w64;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      w_op = 2'(i % 4);
      w_a = {$urandom, $urandom};
      w_b = {$urandom, $urandom};
      exp = ref_op(w_op, w_a, w_b);
      w_in_valid = 1'b1;
      tick;
      w_in_valid = 1'b0; w_a = ~w_a; w_b = ~w_b; w_op = ~w_op;
      lat = -1;
      for (int c = 1; c <= 50; c++) begin
        tick;
        if (w_out_valid) begin lat = c; break; end
      end
      tests++; if (lat != 16) begin fails++; $display("FAIL w64_latency[%0d]: got %0d expected 16", i, lat); end
      tests++; if (w_result !== exp || w_zero !== (exp == 64'h0)) begin fails++; $display("FAIL w64_result[%0d]: got %h/%b expected %h/%b", i, w_result, w_zero, exp, exp == 64'h0); end
`ifdef SEQ_LOGIC_UNIT_POPCOUNT_EN
      tests++; if (int'(w_popcount) != $countones(exp)) begin fails++; $display("FAIL w64_popcount[%0d]: got %0d expected %0d", i, w_popcount, $countones(exp)); end
`endif
      w_out_ready = 1'b1;
      tick;
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_op = 2'b00; d_a = '0; d_b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = 2'b00; w_a = '0; w_b = '0;
    test_reset;
    test_ops;
    test_back_to_back;
    test_mid_reset;
    test_k1;
    test_w64;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
